// File: rtl/lpc_defs.sv
// Shared LPC definitions: FSM state encodings, cycle-type codes and SYNC codes
// used by lpc_frame_decoder.
package lpc_defs;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_CYCTYPE = 3'd2;
    localparam logic [2:0] ST_ADDR    = 3'd3;
    localparam logic [2:0] ST_DATA_LO = 3'd4;
    localparam logic [2:0] ST_DATA_HI = 3'd5;
    localparam logic [2:0] ST_TAR     = 3'd6;
    localparam logic [2:0] ST_SYNC    = 3'd7;

    localparam logic [1:0] CYC_IO  = 2'b00;
    localparam logic [1:0] CYC_MEM = 2'b01;
    localparam logic [1:0] CYC_DMA = 2'b10;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

endpackage

// File: rtl/lpc_frame_decoder.sv
// LPC I/O and memory cycle decoder (target side, passive observer of LAD/LFRAME#).
// Define LPC_SYNC_TIMEOUT_EN to abort frames stuck in SYNC wait for SYNC_TIMEOUT clocks.
module lpc_frame_decoder
    import lpc_defs::*;
#(
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  lpc_cyctype_dir,
    output logic [31:0] lpc_addr,
    output logic [7:0]  lpc_data,
    output logic        lpc_frame_done
);

    if (SYNC_TIMEOUT < 1 || SYNC_TIMEOUT > 255) begin : g_bad_timeout
        $error("lpc_frame_decoder: SYNC_TIMEOUT must be in 1..255");
    end

    logic [2:0]  state;
    logic [2:0]  nib_cnt;
    logic [3:0]  cyc_sh;
    logic [31:0] addr_sh;
    logic [7:0]  data_sh;

    logic start_seen;
    logic is_write;
    logic addr_last;

`ifdef LPC_SYNC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);
    logic [7:0] sync_cnt;
`endif

    assign start_seen = !lpc_frame && (lpc_ad == 4'h0);
    assign is_write   = cyc_sh[1];
    assign addr_last  = (cyc_sh[3:2] == CYC_MEM) ? (nib_cnt == 3'd7) : (nib_cnt == 3'd3);

    // The cycle-type nibble is captured on the first LFRAME#-high clock leaving START;
    // CYCTYPE then validates it while the first address nibble is on the bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            nib_cnt         <= 3'd0;
            cyc_sh          <= 4'h0;
            addr_sh         <= 32'h0;
            data_sh         <= 8'h0;
            lpc_cyctype_dir <= 4'h0;
            lpc_addr        <= 32'h0;
            lpc_data        <= 8'h0;
            lpc_frame_done  <= 1'b0;
`ifdef LPC_SYNC_TIMEOUT_EN
            sync_cnt        <= 8'd0;
`endif
        end else begin
            lpc_frame_done <= 1'b0;
            if (start_seen) begin
                state   <= ST_START;
                nib_cnt <= 3'd0;
            end else if (!lpc_frame) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_START: begin
                        cyc_sh <= {lpc_ad[3:1], 1'b0};
                        state  <= ST_CYCTYPE;
                    end
                    ST_CYCTYPE: begin
                        if (cyc_sh[3]) begin
                            state <= ST_IDLE;
                        end else begin
                            addr_sh <= {28'h0, lpc_ad};
                            nib_cnt <= 3'd1;
                            state   <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_sh <= {addr_sh[27:0], lpc_ad};
                        if (addr_last) begin
                            nib_cnt <= 3'd0;
                            state   <= is_write ? ST_DATA_LO : ST_TAR;
                        end else begin
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                    ST_DATA_LO: begin
                        data_sh[3:0] <= lpc_ad;
                        state        <= ST_DATA_HI;
                    end
                    ST_DATA_HI: begin
                        if (is_write) begin
                            data_sh[7:4] <= lpc_ad;
                            state        <= ST_TAR;
                        end else begin
                            lpc_cyctype_dir <= cyc_sh;
                            lpc_addr        <= addr_sh;
                            lpc_data        <= {lpc_ad, data_sh[3:0]};
                            lpc_frame_done  <= 1'b1;
                            state           <= ST_IDLE;
                        end
                    end
                    ST_TAR: begin
                        if (nib_cnt == 3'd0) begin
                            nib_cnt <= 3'd1;
                        end else begin
                            nib_cnt <= 3'd0;
                            state   <= ST_SYNC;
`ifdef LPC_SYNC_TIMEOUT_EN
                            sync_cnt <= 8'd0;
`endif
                        end
                    end
                    ST_SYNC: begin
                        case (lpc_ad)
                            SYNC_READY: begin
                                if (is_write) begin
                                    lpc_cyctype_dir <= cyc_sh;
                                    lpc_addr        <= addr_sh;
                                    lpc_data        <= data_sh;
                                    lpc_frame_done  <= 1'b1;
                                    state           <= ST_IDLE;
                                end else begin
                                    state <= ST_DATA_LO;
                                end
                            end
                            SYNC_SHORT, SYNC_LONG: begin
`ifdef LPC_SYNC_TIMEOUT_EN
                                if (sync_cnt == TIMEOUT_LAST) begin
                                    state <= ST_IDLE;
                                end else begin
                                    sync_cnt <= sync_cnt + 8'd1;
                                end
`else
                                state <= ST_SYNC;
`endif
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_frame_decoder.sv
// Directed self-checking bench for lpc_frame_decoder; covers the SYNC timeout
// variant when LPC_SYNC_TIMEOUT_EN is defined.
module tb_lpc_frame_decoder;

    logic        clock;
    logic        reset;
    logic [3:0]  lpc_ad;
    logic        lpc_frame;
    logic [3:0]  lpc_cyctype_dir;
    logic [31:0] lpc_addr;
    logic [7:0]  lpc_data;
    logic        lpc_frame_done;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;

    lpc_frame_decoder #(.SYNC_TIMEOUT(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .lpc_ad         (lpc_ad),
        .lpc_frame      (lpc_frame),
        .lpc_cyctype_dir(lpc_cyctype_dir),
        .lpc_addr       (lpc_addr),
        .lpc_data       (lpc_data),
        .lpc_frame_done (lpc_frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each completion pulse is high for one full cycle, so it is seen at exactly one falling edge.
    always @(negedge clock) begin
        if (lpc_frame_done === 1'b1) pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic frame, input logic [3:0] ad);
        @(negedge clock);
        lpc_frame = frame;
        lpc_ad    = ad;
    endtask

    task automatic sendNibs(input bit [127:0] seq, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, seq[4*(n-1-i) +: 4]);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 4'hF);
    endtask

    task automatic checkFrame(input string tag, input int exp_pulses, input logic [3:0] cyc,
                              input logic [31:0] addr, input logic [7:0] data);
        checkOutput({tag, "_pulses"}, 32'(pulses - p0), 32'(exp_pulses));
        checkOutput({tag, "_cyc"}, {28'h0, lpc_cyctype_dir}, {28'h0, cyc});
        checkOutput({tag, "_addr"}, lpc_addr, addr);
        checkOutput({tag, "_data"}, {24'h0, lpc_data}, {24'h0, data});
    endtask

    initial begin
        reset     = 1'b0;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        repeat (3) @(negedge clock);
        checkOutput("rst_cyc", {28'h0, lpc_cyctype_dir}, 32'h0);
        checkOutput("rst_addr", lpc_addr, 32'h0);
        checkOutput("rst_data", {24'h0, lpc_data}, 32'h0);
        checkOutput("rst_done", {31'h0, lpc_frame_done}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        idleCycles(2);

        // I/O write 0x0080 <- 0xA5, trailing TAR ignored
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h200805AFF0, 10);
        idleCycles(3);
        checkFrame("io_wr", 1, 4'h2, 32'h0000_0080, 8'hA5);
        checkOutput("io_wr_done_low", {31'h0, lpc_frame_done}, 32'h0);

        // Memory read of 0xFFFFFFF0 with three long waits
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h4FFFFFFF0FF6660C3, 17);
        idleCycles(3);
        checkFrame("mem_rd", 1, 4'h4, 32'hFFFF_FFF0, 8'h3C);

        // Abort after two address nibbles, then a clean I/O write
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h200, 3);
        applyStimulus(1'b0, 4'hF);
        idleCycles(2);
        checkFrame("abort", 0, 4'h4, 32'hFFFF_FFF0, 8'h3C);
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h2006011FF0, 10);
        idleCycles(3);
        checkFrame("after_abort", 1, 4'h2, 32'h0000_0060, 8'h11);

        // DMA cycle type is dropped, the rest of its nibbles ignored
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h8006011FF0, 10);
        idleCycles(3);
        checkFrame("dma", 0, 4'h2, 32'h0000_0060, 8'h11);

        // SYNC error on an I/O write is dropped
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h2009977FFA0, 11);
        idleCycles(3);
        checkFrame("sync_err", 0, 4'h2, 32'h0000_0060, 8'h11);

        // Back-to-back: START directly after the completing SYNC nibble
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h21234B5FF0, 10);
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h612345678A9FF50, 15);
        idleCycles(3);
        checkFrame("b2b", 2, 4'h6, 32'h1234_5678, 8'h9A);

        // Reset during DATA_LO, then a clean I/O read
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h20080, 5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midrst_cyc", {28'h0, lpc_cyctype_dir}, 32'h0);
        checkOutput("midrst_addr", lpc_addr, 32'h0);
        checkOutput("midrst_data", {24'h0, lpc_data}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h00080FF0A5, 10);
        idleCycles(3);
        checkFrame("rd_after_rst", 1, 4'h0, 32'h0000_0080, 8'h5A);

`ifdef LPC_SYNC_TIMEOUT_EN
        // 64 consecutive wait nibbles time out; the late READY is ignored
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h203F87EFF, 9);
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 4'h6);
        applyStimulus(1'b1, 4'h0);
        idleCycles(3);
        checkFrame("sync_timeout", 0, 4'h0, 32'h0000_0080, 8'h5A);

        // 63 wait nibbles are still within the limit
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h203F87EFF, 9);
        for (int i = 0; i < 63; i++) applyStimulus(1'b1, 4'h6);
        applyStimulus(1'b1, 4'h0);
        idleCycles(3);
        checkFrame("sync_63", 1, 4'h2, 32'h0000_03F8, 8'hE7);
`else
        // Without the timeout, a 200-clock wait still completes
        p0 = pulses;
        applyStimulus(1'b0, 4'h0);
        sendNibs(128'h203F87EFF, 9);
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 4'h6);
        applyStimulus(1'b1, 4'h0);
        idleCycles(3);
        checkFrame("sync_long", 1, 4'h2, 32'h0000_03F8, 8'hE7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
